memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Two-port (instruction read / data read-write) round-robin arbiter onto a single memory port.
// Define MEMORY_ARBITER_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles with err set.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_write_val,
  input  logic [31:0] mem_read_val,
  input  logic        mem_response
);

  localparam int unsigned DW = 32;
  localparam int unsigned DRAIN_W = 2;

  typedef enum logic [1:0] {DRAIN, IDLE, ISSUE, WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic               r_owner_d, w_owner_d_nxt;
  logic               r_we, w_we_nxt;
  logic [DW-1:0]      r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0]      r_mem_wval, w_mem_wval_nxt;
  logic               r_read_en, w_read_en_nxt;
  logic               r_write_en, w_write_en_nxt;
  logic               r_i_ack, w_i_ack_nxt;
  logic               r_d_ack, w_d_ack_nxt;
  logic               r_err, w_err_nxt;
  logic [DW-1:0]      r_i_rdata, w_i_rdata_nxt;
  logic [DW-1:0]      r_d_rdata, w_d_rdata_nxt;
  logic               w_i_elig, w_d_elig, w_grant, w_grant_d, w_timeout;

  // A port being acked this cycle is still holding its request; keep it out of the race.
  assign w_i_elig  = i_req & ~r_i_ack;
  assign w_d_elig  = d_req & ~r_d_ack;
  assign w_grant   = w_i_elig | w_d_elig;
  assign w_grant_d = w_d_elig & (~w_i_elig | ~r_owner_d);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt;

  // Counts WAIT cycles; cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk) begin
    if (reset || r_state != WAIT) r_wait_cnt <= 8'd0;
    else                          r_wait_cnt <= r_wait_cnt + 8'd1;
  end

  assign w_timeout = (r_state == WAIT) & ~mem_response & (r_wait_cnt == TIMEOUT_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= DRAIN;
      r_drain_cnt <= '0;
      r_owner_d   <= 1'b1;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wval  <= '0;
      r_read_en   <= 1'b0;
      r_write_en  <= 1'b0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_err       <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_owner_d   <= w_owner_d_nxt;
      r_we        <= w_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wval  <= w_mem_wval_nxt;
      r_read_en   <= w_read_en_nxt;
      r_write_en  <= w_write_en_nxt;
      r_i_ack     <= w_i_ack_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_err       <= w_err_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DRAIN:   if (r_drain_cnt == 2'd2) w_state_nxt = IDLE;
      IDLE:    if (w_grant) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT: begin
        if (mem_response)   w_state_nxt = IDLE;
        else if (w_timeout) w_state_nxt = DRAIN;
      end
      default: w_state_nxt = DRAIN;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    w_drain_cnt_nxt = '0;
    w_owner_d_nxt   = r_owner_d;
    w_we_nxt        = r_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wval_nxt  = r_mem_wval;
    w_read_en_nxt   = 1'b0;
    w_write_en_nxt  = 1'b0;
    w_i_ack_nxt     = 1'b0;
    w_d_ack_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_i_rdata_nxt   = r_i_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    case (r_state)
      DRAIN: w_drain_cnt_nxt = r_drain_cnt + 2'd1;
      IDLE: begin
        if (w_grant) begin
          w_owner_d_nxt  = w_grant_d;
          w_we_nxt       = w_grant_d & d_we;
          w_mem_addr_nxt = w_grant_d ? d_addr : i_addr;
          if (w_grant_d && d_we) w_mem_wval_nxt = d_wdata;
          w_read_en_nxt  = ~(w_grant_d & d_we);
          w_write_en_nxt = w_grant_d & d_we;
        end
      end
      WAIT: begin
        if (mem_response) begin
          if (r_owner_d) begin
            w_d_ack_nxt = 1'b1;
            if (!r_we) w_d_rdata_nxt = mem_read_val;
          end else begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = mem_read_val;
          end
        end else if (w_timeout) begin
          w_err_nxt = 1'b1;
          if (r_owner_d) begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = '0;
          end else begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign i_rdata       = r_i_rdata;
  assign i_ack         = r_i_ack;
  assign d_rdata       = r_d_rdata;
  assign d_ack         = r_d_ack;
  assign err           = r_err;
  assign mem_addr      = r_mem_addr;
  assign mem_read_en   = r_read_en;
  assign mem_write_en  = r_write_en;
  assign mem_write_val = r_mem_wval;

endmodule
